// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage -- IF stage of the 5-stage MIPS pipeline.
//
// Owns the fetch PC, issues instruction-memory requests and loads the IF/ID
// register. Redirect targets come from the D-stage next-PC logic; the delay
// slot instruction (branch PC + 4) always reaches D. When D stalls while a
// response is arriving, the word is parked in a one-entry buffer (HOLD state).
//
// Optional feature macro: FETCH_ADEL_EN
//   defined   -> misaligned / out-of-window fetch addresses are not requested;
//                they flow into IF/ID as instr 0 with exc_adel_d = 1.
//   undefined -> every address is requested and exc_adel_d is always 0.
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter int unsigned IM_BYTES = 16384
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] npc_in,
  input  logic        npc_redirect,
  input  logic        stall_d,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic [31:0] im_rdata,
  input  logic        im_valid,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc8_d,
  output logic        valid_d,
  output logic        exc_adel_d
);

  localparam logic [0:0] S_FETCH = 1'b0;
  localparam logic [0:0] S_HOLD  = 1'b1;

  // Architectural / pipeline state
  logic [0:0]  r_state;
  logic [31:0] r_pc_f;
  logic        r_pend;
  logic [31:0] r_pend_tgt;
  logic [31:0] r_buf_instr;
  logic        r_buf_exc;
  logic [31:0] r_instr_d;
  logic [31:0] r_pc_d;
  logic [31:0] r_pc8_d;
  logic        r_valid_d;
  logic        r_exc_adel_d;

  // Combinational helpers
  logic        w_in_fetch;
  logic        w_bad;
  logic        w_resp;
  logic [31:0] w_resp_instr;
  logic        w_redir_now;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_pc_plus8;
  logic [31:0] w_next_pc;
  logic        w_fetch_done;
  logic        w_capture;
  logic        w_release;
  logic        w_advance;
  logic        w_bubble;
  logic [31:0] w_ld_instr;
  logic        w_ld_exc;

  assign w_in_fetch = (r_state == S_FETCH);
  assign w_pc_plus4 = r_pc_f + 32'd4;
  assign w_pc_plus8 = r_pc_f + 32'd8;

`ifdef FETCH_ADEL_EN
  // Upper bound computed in 33 bits so a window touching 2^32 does not wrap.
  localparam logic [32:0] IM_LIMIT = {1'b0, IM_BASE} + 33'(IM_BYTES);

  assign w_bad = (r_pc_f[1:0] != 2'b00) |
                 (r_pc_f < IM_BASE) |
                 ({1'b0, r_pc_f} >= IM_LIMIT);
`else
  assign w_bad = 1'b0;
`endif

  // A bad address behaves like an immediate response carrying a null word.
  assign w_resp       = w_in_fetch & (im_valid | w_bad);
  assign w_resp_instr = w_bad ? 32'd0 : im_rdata;

  // Redirect only counts for a real, advancing D-stage instruction.
  assign w_redir_now = npc_redirect & r_valid_d & ~stall_d;

  // Next fetch PC: a deferred target wins, since it belongs to the branch
  // whose delay slot is the fetch just finishing.
  always_comb begin
    w_next_pc = w_pc_plus4;
    if (r_pend) begin
      w_next_pc = r_pend_tgt;
    end else if (w_redir_now) begin
      w_next_pc = npc_in;
    end
  end

  // Control decode for the current cycle
  assign w_fetch_done = w_resp & ~stall_d;
  assign w_capture    = w_resp & stall_d;
  assign w_release    = (r_state == S_HOLD) & ~stall_d;
  assign w_advance    = w_fetch_done | w_release;
  assign w_bubble     = w_in_fetch & ~w_resp & ~stall_d;

  assign w_ld_instr = w_release ? r_buf_instr : w_resp_instr;
  assign w_ld_exc   = w_release ? r_buf_exc   : w_bad;

  // Request is withheld during reset, in HOLD and for a faulting address;
  // im_addr only moves when a fetch retires, so it is stable while waiting.
  assign im_req  = rst_n & w_in_fetch & ~w_bad;
  assign im_addr = r_pc_f;

  // FETCH/HOLD state machine
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
    end else if (w_capture) begin
      r_state <= S_HOLD;
    end else if (w_release) begin
      r_state <= S_FETCH;
    end
  end

  // Fetch PC advances only when an instruction retires into IF/ID
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc_f <= RESET_PC;
    end else if (w_advance) begin
      r_pc_f <= w_next_pc;
    end
  end

  // Deferred redirect: branch leaves D before its delay slot has returned.
  // A second redirect while one is pending is illegal and simply dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend     <= 1'b0;
      r_pend_tgt <= 32'd0;
    end else if (w_advance) begin
      r_pend <= 1'b0;
    end else if (w_bubble && w_redir_now && !r_pend) begin
      r_pend     <= 1'b1;
      r_pend_tgt <= npc_in;
    end
  end

  // One-entry response buffer used while D is stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf_instr <= 32'd0;
      r_buf_exc   <= 1'b0;
    end else if (w_capture) begin
      r_buf_instr <= w_resp_instr;
      r_buf_exc   <= w_bad;
    end
  end

  // IF/ID register: load retiring instruction, insert bubble, or hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr_d    <= 32'd0;
      r_pc_d       <= 32'd0;
      r_pc8_d      <= 32'd8;
      r_valid_d    <= 1'b0;
      r_exc_adel_d <= 1'b0;
    end else if (w_advance) begin
      r_instr_d    <= w_ld_instr;
      r_pc_d       <= r_pc_f;
      r_pc8_d      <= w_pc_plus8;
      r_valid_d    <= 1'b1;
      r_exc_adel_d <= w_ld_exc;
    end else if (w_bubble) begin
      r_instr_d    <= 32'd0;
      r_valid_d    <= 1'b0;
      r_exc_adel_d <= 1'b0;
    end
  end

  assign instr_d    = r_instr_d;
  assign pc_d       = r_pc_d;
  assign pc8_d      = r_pc8_d;
  assign valid_d    = r_valid_d;
  assign exc_adel_d = r_exc_adel_d;

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage -- directed, table-driven bench for fetch_stage.
// Each table row is one clock: inputs driven on the falling edge, outputs
// compared 1 ns after the following rising edge.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] npc_in;
  logic        npc_redirect;
  logic        stall_d;
  logic        im_req;
  logic [31:0] im_addr;
  logic [31:0] im_rdata;
  logic        im_valid;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pc8_d;
  logic        valid_d;
  logic        exc_adel_d;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .npc_in       (npc_in),
    .npc_redirect (npc_redirect),
    .stall_d      (stall_d),
    .im_req       (im_req),
    .im_addr      (im_addr),
    .im_rdata     (im_rdata),
    .im_valid     (im_valid),
    .instr_d      (instr_d),
    .pc_d         (pc_d),
    .pc8_d        (pc8_d),
    .valid_d      (valid_d),
    .exc_adel_d   (exc_adel_d)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic        iv;
    logic        rd;
    logic [31:0] data;
    logic [31:0] npc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_vd;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
  } vec_t;

  localparam int NV = 21;
  vec_t vt [NV];

  // Distinct instruction word per address
  function automatic logic [31:0] iw(input logic [31:0] a);
    return 32'hC000_0000 ^ a;
  endfunction

  function automatic vec_t mk(input logic st, input logic iv, input logic rd,
                              input logic [31:0] data, input logic [31:0] npc,
                              input logic e_req, input logic [31:0] e_addr,
                              input logic e_vd, input logic [31:0] e_pc,
                              input logic [31:0] e_instr);
    vec_t v;
    v.st = st; v.iv = iv; v.rd = rd; v.data = data; v.npc = npc;
    v.e_req = e_req; v.e_addr = e_addr; v.e_vd = e_vd;
    v.e_pc = e_pc; v.e_instr = e_instr;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic e_req, input logic [31:0] e_addr,
                         input logic e_vd, input logic [31:0] e_pc,
                         input logic [31:0] e_instr, input logic e_exc);
    chk({tag, ".im_req"},  32'(im_req),     32'(e_req));
    chk({tag, ".im_addr"}, im_addr,         e_addr);
    chk({tag, ".valid_d"}, 32'(valid_d),    32'(e_vd));
    chk({tag, ".pc_d"},    pc_d,            e_pc);
    chk({tag, ".pc8_d"},   pc8_d,           e_pc + 32'd8);
    chk({tag, ".instr_d"}, instr_d,         e_instr);
    chk({tag, ".exc"},     32'(exc_adel_d), 32'(e_exc));
  endtask

  task automatic drive(input logic st, input logic iv, input logic rd,
                       input logic [31:0] data, input logic [31:0] npc);
    stall_d = st; im_valid = iv; npc_redirect = rd; im_rdata = data; npc_in = npc;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Table: taken beq at 3004, jr 3200 during slow slot fetch, stall/HOLD,
    // bubble, redirect ignored while stalled, PC wrap at 2^32.
    vt[0]  = mk(0,1,0,iw(32'h3000),0,            1,32'h3004,1,32'h3000,iw(32'h3000));
    vt[1]  = mk(0,1,0,iw(32'h3004),0,            1,32'h3008,1,32'h3004,iw(32'h3004));
    vt[2]  = mk(0,1,1,iw(32'h3008),32'h3100,     1,32'h3100,1,32'h3008,iw(32'h3008));
    vt[3]  = mk(0,1,0,iw(32'h3100),0,            1,32'h3104,1,32'h3100,iw(32'h3100));
    vt[4]  = mk(0,1,0,iw(32'h3104),0,            1,32'h3108,1,32'h3104,iw(32'h3104));
    vt[5]  = mk(0,0,1,32'h0,32'h3200,            1,32'h3108,0,32'h3104,32'h0);
    vt[6]  = mk(0,0,1,32'h0,32'h3200,            1,32'h3108,0,32'h3104,32'h0);
    vt[7]  = mk(0,1,0,iw(32'h3108),0,            1,32'h3200,1,32'h3108,iw(32'h3108));
    vt[8]  = mk(0,1,0,iw(32'h3200),0,            1,32'h3204,1,32'h3200,iw(32'h3200));
    vt[9]  = mk(1,1,0,iw(32'h3204),0,            0,32'h3204,1,32'h3200,iw(32'h3200));
    vt[10] = mk(1,0,0,32'h0,0,                   0,32'h3204,1,32'h3200,iw(32'h3200));
    vt[11] = mk(1,1,0,32'hDEAD_BEEF,0,           0,32'h3204,1,32'h3200,iw(32'h3200));
    vt[12] = mk(1,0,1,32'h0,32'h3F00,            0,32'h3204,1,32'h3200,iw(32'h3200));
    vt[13] = mk(0,0,0,32'h0,0,                   1,32'h3208,1,32'h3204,iw(32'h3204));
    vt[14] = mk(0,1,0,iw(32'h3208),0,            1,32'h320C,1,32'h3208,iw(32'h3208));
    vt[15] = mk(1,0,0,32'h0,0,                   1,32'h320C,1,32'h3208,iw(32'h3208));
    vt[16] = mk(0,0,0,32'h0,0,                   1,32'h320C,0,32'h3208,32'h0);
    vt[17] = mk(0,1,0,iw(32'h320C),0,            1,32'h3210,1,32'h320C,iw(32'h320C));
    vt[18] = mk(0,1,1,iw(32'h3210),32'hFFFF_FFFC,1,32'hFFFF_FFFC,1,32'h3210,iw(32'h3210));
    vt[19] = mk(0,1,0,iw(32'hFFFF_FFFC),0,       1,32'h0,1,32'hFFFF_FFFC,iw(32'hFFFF_FFFC));
    vt[20] = mk(0,1,0,iw(32'h0),0,               1,32'h4,1,32'h0,iw(32'h0));

    // Reset state
    rst_n = 1'b0;
    drive(0,0,0,32'h0,32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 1'b0, 32'h3000, 1'b0, 32'h0, 32'h0, 1'b0);

    // Release: request asserts combinationally in the first active cycle
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel.im_req", 32'(im_req), 32'd1);
    chk("rel.im_addr", im_addr, 32'h3000);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vt[i].st, vt[i].iv, vt[i].rd, vt[i].data, vt[i].npc);
      @(posedge clk);
      #1;
      chk_all($sformatf("row%0d", i), vt[i].e_req, vt[i].e_addr, vt[i].e_vd,
              vt[i].e_pc, vt[i].e_instr, 1'b0);
    end

    // Enter HOLD, then reset asynchronously mid-HOLD
    @(negedge clk);
    drive(1,1,0,iw(32'h4),0);
    @(posedge clk);
    #1;
    chk_all("hold", 1'b0, 32'h4, 1'b1, 32'h0, iw(32'h0), 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    drive(0,0,0,32'h0,32'h0);
    #1;
    chk_all("rsthold", 1'b0, 32'h3000, 1'b0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rsthold.req", 32'(im_req), 32'd1);
    @(posedge clk);
    #1;
    chk("rsthold.bubble_vd", 32'(valid_d), 32'd0);
    // No stale pending target: sequential fetch continues at 3004
    @(negedge clk);
    drive(0,1,0,iw(32'h3000),0);
    @(posedge clk);
    #1;
    chk_all("post_rst", 1'b1, 32'h3004, 1'b1, 32'h3000, iw(32'h3000), 1'b0);

    // jr to misaligned 3002 from D
    @(negedge clk);
    drive(0,1,1,iw(32'h3004),32'h3002);
    @(posedge clk);
    #1;
`ifdef FETCH_ADEL_EN
    chk_all("jr3002", 1'b0, 32'h3002, 1'b1, 32'h3004, iw(32'h3004), 1'b0);
`else
    chk_all("jr3002", 1'b1, 32'h3002, 1'b1, 32'h3004, iw(32'h3004), 1'b0);
`endif
    @(negedge clk);
    drive(0,1,0,iw(32'h3002),0);
    @(posedge clk);
    #1;
`ifdef FETCH_ADEL_EN
    chk_all("adel", 1'b0, 32'h3006, 1'b1, 32'h3002, 32'h0, 1'b1);
`else
    chk_all("adel", 1'b1, 32'h3006, 1'b1, 32'h3002, iw(32'h3002), 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
